// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode encodings, sequencer state encoding, legality helper.
// Imported by the sequencer and the opcode decoder so both agree on the ISA.
package cpu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
    localparam logic [OP_W-1:0] OP_LOADA = 6'h01;
    localparam logic [OP_W-1:0] OP_LOADB = 6'h02;
    localparam logic [OP_W-1:0] OP_ADD   = 6'h03;
    localparam logic [OP_W-1:0] OP_SUB   = 6'h04;
    localparam logic [OP_W-1:0] OP_AND   = 6'h05;
    localparam logic [OP_W-1:0] OP_OR    = 6'h06;
    localparam logic [OP_W-1:0] OP_XOR   = 6'h07;
    localparam logic [OP_W-1:0] OP_JMP   = 6'h08;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_EXEC,
        SEQ_HALTED
    } seq_state_t;

    // Encodings are dense from NOP up to JMP, plus the lone HALT at the top.
    function automatic logic is_defined_op(input logic [OP_W-1:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns pc, IR and retired counter; drives the imem request.
// Latency: 2 cycles/instruction with zero-wait memory; FETCH holds imem_req until imem_valid.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int  PC_W    = 8,
    parameter int  INSTR_W = 16,
    parameter int  CNT_W   = 16,
    localparam int IMM_W   = INSTR_W - OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [OP_W-1:0]    opcode,
    output logic [IMM_W-1:0]   imm,
    output logic               exec_en,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    seq_state_t          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic [OP_W-1:0]     ir_op;
    logic [IMM_W-1:0]    ir_imm;

    assign ir_op  = ir_q[INSTR_W-1 -: OP_W];
    assign ir_imm = ir_q[IMM_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        retired_d = retired_q;

        unique case (state_q)
            SEQ_IDLE, SEQ_HALTED: begin
                if (start) begin
                    pc_d      = '0;
                    illegal_d = 1'b0;
                    retired_d = '0;
                    state_d   = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                state_d = SEQ_FETCH;
                if (ir_op == OP_JMP) begin
                    // Only the low PC_W immediate bits address the instruction memory.
                    pc_d = ir_imm[PC_W-1:0];
                end else if (ir_op == OP_HALT) begin
                    state_d = SEQ_HALTED;
                end else begin
                    // Undefined opcodes retire like NOP but leave the sticky flag set.
                    if (!is_defined_op(ir_op)) begin
                        illegal_d = 1'b1;
                    end
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // All outputs decode directly from registered state, so reset clears them asynchronously.
    assign imem_req  = (state_q == SEQ_FETCH);
    assign imem_addr = pc_q;
    assign exec_en   = (state_q == SEQ_EXEC);
    assign opcode    = (state_q == SEQ_EXEC) ? ir_op : '0;
    assign imm       = ir_imm;
    assign busy      = (state_q == SEQ_FETCH) || (state_q == SEQ_EXEC);
    assign halted    = (state_q == SEQ_HALTED);
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs, expected executes queued per run.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [5:0]  opcode;
    logic [9:0]  imm;
    logic        exec_en, busy, halted, illegal;
    logic [15:0] retired;

    logic        sat_start = 1'b0;
    logic        sat_req, sat_exec_en, sat_busy, sat_halted, sat_illegal;
    logic [7:0]  sat_addr;
    logic [5:0]  sat_opcode;
    logic [9:0]  sat_imm;
    logic [3:0]  sat_retired;
    logic [15:0] sat_rdata = 16'h2000;

    always #5 clk = ~clk;

    cpu_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .opcode(opcode), .imm(imm), .exec_en(exec_en), .busy(busy),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    // Small counter width so saturation is reachable: JMP-to-self loop at address 0.
    cpu_sequencer #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(sat_start),
        .imem_req(sat_req), .imem_addr(sat_addr),
        .imem_valid(sat_req), .imem_rdata(sat_rdata),
        .opcode(sat_opcode), .imm(sat_imm), .exec_en(sat_exec_en), .busy(sat_busy),
        .halted(sat_halted), .illegal(sat_illegal), .retired(sat_retired)
    );

    typedef struct {
        logic [5:0]  op;
        logic [9:0]  imm;
        logic [7:0]  addr;
        int          gap;
        int          reqlen;
        logic        ill;
        logic [15:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] mem[256];
    logic        mem_en = 1'b1;
    int          wait_n = 0;
    int          wcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [9:0] im, input logic [7:0] a,
                        input int gap, input int rl, input logic il, input logic [15:0] rt);
        exp_t e;
        e.op = op; e.imm = im; e.addr = a; e.gap = gap; e.reqlen = rl; e.ill = il; e.ret = rt;
        exp_q.push_back(e);
    endtask

    // Memory model: answers after wait_n idle request cycles.
    always begin
        @(posedge clk);
        #1;
        if (mem_en) begin
            if (imem_req) begin
                if (wcnt >= wait_n) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[imem_addr];
                end else begin
                    imem_valid = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_valid = 1'b0;
                wcnt = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: tracks request duration/address stability and checks each execute strobe.
    int         cyc = 0;
    int         last_exec = 0;
    int         req_len = 0;
    logic [7:0] fetch_addr = '0;
    always begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst) begin
            req_len = 0;
        end else begin
            if (imem_req) begin
                if (req_len == 0) fetch_addr = imem_addr;
                else chk("addr_stable", imem_addr, fetch_addr);
                req_len++;
            end
            if (exec_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_exec", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("exec_opcode", opcode, e.op);
                    chk("exec_imm", imm, e.imm);
                    chk("exec_fetch_addr", fetch_addr, e.addr);
                    chk("exec_req_len", req_len, e.reqlen);
                    chk("exec_illegal", illegal, e.ill);
                    chk("exec_retired", retired, e.ret);
                    if (e.gap != 0) chk("exec_spacing", cyc - last_exec, e.gap);
                end
                req_len = 0;
                last_exec = cyc;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_halted(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    task automatic load_prog1();
        mem[0] = 16'h0405;  // LOADA 5
        mem[1] = 16'h0803;  // LOADB 3
        mem[2] = 16'h0C00;  // ADD
        mem[3] = 16'hFC00;  // HALT
    endtask

    task automatic push_prog1(input int gap, input int rl);
        push(6'h01, 10'd5, 8'd0, 0,   rl, 1'b0, 16'd0);
        push(6'h02, 10'd3, 8'd1, gap, rl, 1'b0, 16'd1);
        push(6'h03, 10'd0, 8'd2, gap, rl, 1'b0, 16'd2);
        push(6'h3F, 10'd0, 8'd3, gap, rl, 1'b0, 16'd3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_imm", imm, 0);
        chk("rst_exec_en", exec_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_retired", retired, 0);
        @(posedge clk); #1 sat_start = 1'b1;
        @(posedge clk); #1 sat_start = 1'b0;

        // Program 1, zero wait.
        load_prog1();
        wait_n = 0;
        push_prog1(2, 1);
        do_start();
        wait_halted(40);
        chk("p1_retired", retired, 4);
        chk("p1_pc", imem_addr, 3);
        chk("p1_busy", busy, 0);
        chk("p1_opcode_idle", opcode, 0);

        // Same program, 3 wait cycles per fetch.
        wait_n = 3;
        push_prog1(5, 4);
        do_start();
        wait_halted(80);
        chk("p2_retired", retired, 4);
        chk("p2_pc", imem_addr, 3);

        // Jumps, ignored upper immediate bits and pc wrap.
        wait_n = 0;
        mem[8'h00] = 16'h2010;  // JMP 0x10
        mem[8'h10] = 16'h23FF;  // JMP imm 0x3FF -> pc 0xFF
        mem[8'hFF] = 16'h0000;  // NOP, pc wraps to 0
        push(6'h08, 10'h010, 8'h00, 0, 1, 1'b0, 16'd0);
        push(6'h08, 10'h3FF, 8'h10, 2, 1, 1'b0, 16'd1);
        push(6'h00, 10'h000, 8'hFF, 2, 1, 1'b0, 16'd2);
        push(6'h3F, 10'h000, 8'h00, 2, 1, 1'b0, 16'd3);
        do_start();
        begin
            int seen = 0;
            for (int i = 0; i < 20 && seen == 0; i++) begin
                @(negedge clk);
                if (exec_en) seen = 1;
            end
            chk("p3_first_exec", seen, 1);
        end
        mem[8'h00] = 16'hFC00;
        wait_halted(40);
        chk("p3_pc", imem_addr, 8'h00);
        chk("p3_illegal", illegal, 0);

        // Illegal opcode 0x15, sticky across later instructions, cleared by restart.
        mem[0] = 16'h542A;
        mem[1] = 16'h0407;
        mem[2] = 16'hFC00;
        for (int r = 0; r < 2; r++) begin
            push(6'h15, 10'h02A, 8'd0, 0, 1, 1'b0, 16'd0);
            push(6'h01, 10'h007, 8'd1, 2, 1, 1'b1, 16'd1);
            push(6'h3F, 10'h000, 8'd2, 2, 1, 1'b1, 16'd2);
            do_start();
            if (r == 1) begin
                @(negedge clk);
                chk("p4_restart_illegal", illegal, 0);
                chk("p4_restart_retired", retired, 0);
                chk("p4_restart_pc", imem_addr, 0);
            end
            wait_halted(40);
            chk("p4_illegal_sticky", illegal, 1);
            chk("p4_pc", imem_addr, 2);
        end

        // start held high through FETCH and EXEC must not disturb the run.
        load_prog1();
        wait_n = 1;
        push_prog1(3, 2);
        @(posedge clk); #1 start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (halted) break;
        end
        start = 1'b0;
        @(negedge clk);
        chk("p6_halted", halted, 1);
        chk("p6_retired", retired, 4);
        chk("sat_retired", sat_retired, 4'hF);
        chk("sat_busy", sat_busy, 1);

        // Reset during a FETCH wait, then a stray imem_valid.
        mem[0] = 16'h0405;
        wait_n = 10;
        do_start();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rst_req_async", imem_req, 0);
        mem_en = 1'b0;
        imem_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 imem_valid = 1'b1; imem_rdata = 16'hFC00;
        @(posedge clk); #1 imem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p5_no_exec", exec_en, 0);
            chk("p5_idle", busy, 0);
        end
        chk("p5_imm", imm, 0);
        chk("p5_halted", halted, 0);
        chk("p5_retired", retired, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
